coin_acceptor: RTL and testbench

Front-end of the vending datapath. Takes the three raw, asynchronous coin-slot sensor lines, synchronises and debounces them, and turns each physical coin into exactly one single-cycle `nickel_in` / `dime_in` / `quarter_in` pulse for the drink machine controller. It rejects ambiguous or inhibited coins (multiple sensors active, or machine empty or dispensing) via a return-gate pulse. It also flags a stuck sensor.

---
 rtl/coin_acceptor.sv | 150 +++++++++++++++
 tb/tb_coin_acceptor.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/coin_acceptor.sv
// ============================================================================
// coin_acceptor : synchronise, debounce and classify three coin-slot sensors
// Revision      : 1.0
// ============================================================================
`default_nettype none

module coin_acceptor #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int STUCK_CYCLES    = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic nickel_sense,
  input  logic dime_sense,
  input  logic quarter_sense,
  input  logic inhibit,
  output logic nickel_in,
  output logic dime_in,
  output logic quarter_in,
  output logic coin_reject,
  output logic busy,
  output logic fault
);

  localparam logic [7:0]  C_DEB_LAST   = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0] C_STUCK_LAST = 16'(STUCK_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    QUALIFY    = 3'd1,
    ACCEPT     = 3'd2,
    REJECT     = 3'd3,
    WAIT_CLEAR = 3'd4
  } state_t;

  state_t      r_state;
  logic [2:0]  r_sync1;
  logic [2:0]  r_sync2;
  logic [2:0]  r_coin;
  logic [7:0]  r_cnt;
  logic [7:0]  r_clr_cnt;
  logic [15:0] r_stuck_cnt;
  logic [2:0]  w_s;
  logic        w_onehot;

  assign w_s      = r_sync2;
  assign w_onehot = (w_s == 3'b001) || (w_s == 3'b010) || (w_s == 3'b100);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 3'b000;
      r_sync2 <= 3'b000;
    end else begin
      r_sync1 <= {quarter_sense, dime_sense, nickel_sense};
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_coin      <= 3'b000;
      r_cnt       <= 8'd0;
      r_clr_cnt   <= 8'd0;
      r_stuck_cnt <= 16'd0;
      nickel_in   <= 1'b0;
      dime_in     <= 1'b0;
      quarter_in  <= 1'b0;
      coin_reject <= 1'b0;
      busy        <= 1'b0;
      fault       <= 1'b0;
    end else begin
      nickel_in   <= 1'b0;
      dime_in     <= 1'b0;
      quarter_in  <= 1'b0;
      coin_reject <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_s != 3'b000) begin
            busy <= 1'b1;
            if (w_onehot) begin
              r_coin  <= w_s;
              r_cnt   <= 8'd1;
              r_state <= QUALIFY;
            end else begin
              r_state <= REJECT;
            end
          end
        end
        QUALIFY: begin
          if (w_s == r_coin) begin
            // inhibit only matters on the sample that completes qualification
            if (r_cnt >= C_DEB_LAST) begin
              r_state <= inhibit ? REJECT : ACCEPT;
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end else if (w_s == 3'b000) begin
            r_cnt   <= 8'd0;
            busy    <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_state <= REJECT;
          end
        end
        ACCEPT: begin
          {quarter_in, dime_in, nickel_in} <= r_coin;
          r_cnt       <= 8'd0;
          r_clr_cnt   <= 8'd0;
          r_stuck_cnt <= 16'd0;
          r_state     <= WAIT_CLEAR;
        end
        REJECT: begin
          coin_reject <= 1'b1;
          r_cnt       <= 8'd0;
          r_clr_cnt   <= 8'd0;
          r_stuck_cnt <= 16'd0;
          r_state     <= WAIT_CLEAR;
        end
        WAIT_CLEAR: begin
          if (w_s == 3'b000) begin
            if (r_clr_cnt >= C_DEB_LAST) begin
              r_clr_cnt <= 8'd0;
              busy      <= 1'b0;
              r_state   <= IDLE;
            end else begin
              r_clr_cnt <= r_clr_cnt + 8'd1;
            end
          end else begin
            r_clr_cnt <= 8'd0;
            if (r_stuck_cnt != 16'hFFFF) begin
              r_stuck_cnt <= r_stuck_cnt + 16'd1;
            end
            // fault is sticky and purely informational
            if (r_stuck_cnt >= C_STUCK_LAST) begin
              fault <= 1'b1;
            end
          end
        end
        default: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_coin_acceptor.sv
// ============================================================================
// tb_coin_acceptor : directed stimulus with a queue-based pulse scoreboard
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_coin_acceptor;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic nickel_sense = 1'b0;
  logic dime_sense = 1'b0;
  logic quarter_sense = 1'b0;
  logic inhibit = 1'b0;
  logic nickel_in, dime_in, quarter_in, coin_reject, busy, fault;

  coin_acceptor dut (
    .clk(clk), .reset(reset),
    .nickel_sense(nickel_sense), .dime_sense(dime_sense), .quarter_sense(quarter_sense),
    .inhibit(inhibit),
    .nickel_in(nickel_in), .dime_in(dime_in), .quarter_in(quarter_in),
    .coin_reject(coin_reject), .busy(busy), .fault(fault)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [3:0] kind;  // {coin_reject, quarter_in, dime_in, nickel_in}
    int         at;
  } exp_t;
  exp_t q[$];

  localparam logic [3:0] K_NICKEL = 4'b0001;
  localparam logic [3:0] K_DIME   = 4'b0010;
  localparam logic [3:0] K_REJECT = 4'b1000;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic goto(input int n);
    while (cyc < n) tick(1);
  endtask

  task automatic expect_pulse(input logic [3:0] kind, input int at);
    exp_t e;
    e.kind = kind;
    e.at   = at;
    q.push_back(e);
  endtask

  // Monitor: every output pulse must match the head of the queue in kind and cycle
  always @(negedge clk) begin : mon
    logic [3:0] k;
    exp_t e;
    k = {coin_reject, quarter_in, dime_in, nickel_in};
    if (k != 4'b0000) begin
      if (q.size() == 0) begin
        chk("unexpected_pulse", int'(k), 0);
      end else begin
        e = q.pop_front();
        chk("pulse_kind", int'(k), int'(e.kind));
        chk("pulse_cycle", cyc, e.at);
      end
    end
  end

  int c;

  initial begin
    // Reset state
    tick(3);
    chk("reset_outputs", int'({nickel_in, dime_in, quarter_in, coin_reject, busy, fault}), 0);
    reset = 1'b0;
    tick(2);
    chk("idle_busy", int'(busy), 0);

    // Clean dime
    c = cyc;
    dime_sense = 1'b1;
    expect_pulse(K_DIME, c + 7);
    goto(c + 2);
    chk("dime_busy_before", int'(busy), 0);
    goto(c + 3);
    chk("dime_busy_qualify", int'(busy), 1);
    goto(c + 10);
    dime_sense = 1'b0;
    goto(c + 15);
    chk("dime_busy_clearing", int'(busy), 1);
    goto(c + 16);
    chk("dime_busy_released", int'(busy), 0);
    goto(c + 20);

    // Quarter glitch, two cycles
    c = cyc;
    quarter_sense = 1'b1;
    goto(c + 2);
    quarter_sense = 1'b0;
    goto(c + 4);
    chk("glitch_busy_qualify", int'(busy), 1);
    goto(c + 6);
    chk("glitch_back_idle", int'(busy), 0);
    goto(c + 20);

    // Nickel and dime together
    c = cyc;
    nickel_sense = 1'b1;
    dime_sense   = 1'b1;
    expect_pulse(K_REJECT, c + 4);
    goto(c + 10);
    nickel_sense = 1'b0;
    dime_sense   = 1'b0;
    goto(c + 20);
    chk("multi_busy_idle", int'(busy), 0);

    // Quarter while inhibited
    c = cyc;
    inhibit       = 1'b1;
    quarter_sense = 1'b1;
    expect_pulse(K_REJECT, c + 7);
    goto(c + 10);
    quarter_sense = 1'b0;
    inhibit       = 1'b0;
    goto(c + 20);

    // Stuck nickel
    c = cyc;
    nickel_sense = 1'b1;
    expect_pulse(K_NICKEL, c + 7);
    goto(c + 1000);
    chk("stuck_fault_early", int'(fault), 0);
    chk("stuck_busy", int'(busy), 1);
    goto(c + 1040);
    chk("stuck_fault_set", int'(fault), 1);
    goto(c + 1100);
    nickel_sense = 1'b0;
    goto(c + 1110);
    chk("stuck_cleared_idle", int'(busy), 0);
    c = cyc;
    dime_sense = 1'b1;
    expect_pulse(K_DIME, c + 7);
    goto(c + 10);
    dime_sense = 1'b0;
    goto(c + 20);
    chk("fault_sticky", int'(fault), 1);
    reset = 1'b1;
    #1;
    chk("fault_reset", int'(fault), 0);
    tick(2);
    reset = 1'b0;
    tick(2);

    // Reset during QUALIFY of a dime
    c = cyc;
    dime_sense = 1'b1;
    goto(c + 4);
    chk("midreset_busy_before", int'(busy), 1);
    reset = 1'b1;
    #1;
    chk("midreset_outputs", int'({nickel_in, dime_in, quarter_in, coin_reject, busy, fault}), 0);
    dime_sense = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(3);
    c = cyc;
    dime_sense = 1'b1;
    expect_pulse(K_DIME, c + 7);
    goto(c + 10);
    dime_sense = 1'b0;
    goto(c + 20);
    chk("final_busy_idle", int'(busy), 0);

    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
